// File: rtl/fpadd_rr_scheduler_pkg.sv
// Shared FP-adder constants, tag payload type and sizing helpers for the
// round-robin adder scheduler.
package fpadd_rr_scheduler_pkg;

    localparam int unsigned FP32_W    = 32;
    localparam int unsigned FPADD_LAT = 2;
    localparam int unsigned MAX_REQ   = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'(1) << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned id_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int unsigned TAG_ID_W = clog2(MAX_REQ);

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpadd_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// i_ptr (wrapping), producing a one-hot grant plus its binary index.
module rr_arbiter
    import fpadd_rr_scheduler_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = id_width(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    input  logic           i_en,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_any_gnt
);

    logic [N-1:0]   w_gnt;
    logic [IDW-1:0] w_gnt_id;
    logic           w_found;
    logic [IDW-1:0] w_idx;

    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        if (i_en) begin
            for (int unsigned k = 0; k < N; k++) begin
                w_idx = IDW'((32'(i_ptr) + k) % N);
                if (!w_found && i_req[w_idx]) begin
                    w_gnt[w_idx] = 1'b1;
                    w_gnt_id     = w_idx;
                    w_found      = 1'b1;
                end
            end
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_id  = w_gnt_id;
    assign o_any_gnt = w_found;

endmodule

// File: rtl/fpadd_rr_scheduler.sv
// Shares one pipelined FP32 adder among N_REQ requesters: round-robin issue,
// a non-stalling tag pipe to route sums back, and an in-flight counter.
module fpadd_rr_scheduler
    import fpadd_rr_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADD_LAT = FPADD_LAT,
    parameter int unsigned W       = FP32_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_hold,
    input  logic [N_REQ-1:0]                i_req_valid,
    input  logic [N_REQ*W-1:0]              i_req_a,
    input  logic [N_REQ*W-1:0]              i_req_b,
    output logic [N_REQ-1:0]                o_req_ready,
    output logic [W-1:0]                    o_fpu_a,
    output logic [W-1:0]                    o_fpu_b,
    input  logic [W-1:0]                    i_fpu_out,
    output logic [N_REQ-1:0]                o_resp_valid,
    output logic [W-1:0]                    o_resp_data,
    output logic [clog2(ADD_LAT+1)-1:0]     o_inflight,
    output logic                            o_busy
);

    localparam int unsigned IDW  = id_width(N_REQ);
    localparam int unsigned IF_W = clog2(ADD_LAT + 1);

    logic [N_REQ-1:0] w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_accept;
    logic             w_resp;
    logic [W-1:0]     w_fpu_a;
    logic [W-1:0]     w_fpu_b;

    logic [IDW-1:0]   r_ptr;
    tag_t             r_tag [ADD_LAT];
    logic [IF_W-1:0]  r_inflight;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .i_req     (i_req_valid),
        .i_ptr     (r_ptr),
        .i_en      (!i_hold && !reset),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id),
        .o_any_gnt (w_accept)
    );

    // Operand mux; zero when idle so the adder sees 0+0, which is never tagged.
    always_comb begin
        w_fpu_a = '0;
        w_fpu_b = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gnt[i]) begin
                w_fpu_a = w_fpu_a | i_req_a[i*W +: W];
                w_fpu_b = w_fpu_b | i_req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + IDW'(1);
        end
    end

    // Tag pipe tracks the adder's fixed latency and never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(ADD_LAT); k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_accept, id: TAG_ID_W'(w_gnt_id)};
            for (int k = 1; k < int'(ADD_LAT); k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_resp = r_tag[ADD_LAT-1].vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_resp})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign o_req_ready  = w_gnt;
    assign o_fpu_a      = w_fpu_a;
    assign o_fpu_b      = w_fpu_b;
    assign o_resp_valid = w_resp ? (N_REQ'(1) << r_tag[ADD_LAT-1].id) : '0;
    assign o_resp_data  = i_fpu_out;
    assign o_inflight   = r_inflight;
    assign o_busy       = (r_inflight != '0) | (|i_req_valid);

endmodule

// File: tb/tb_fpadd_rr_scheduler.sv
// Directed bench for fpadd_rr_scheduler with a 2-edge table-driven FP32 adder.
module tb_fpadd_rr_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic           clk;
    logic           reset;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fpu_a;
    logic [W-1:0]   fpu_b;
    logic [W-1:0]   fpu_out;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic [1:0]     inflight;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    fpadd_rr_scheduler #(.N_REQ(N), .ADD_LAT(2), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_hold       (hold),
        .i_req_valid  (req_valid),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_req_ready  (req_ready),
        .o_fpu_a      (fpu_a),
        .o_fpu_b      (fpu_b),
        .i_fpu_out    (fpu_out),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_inflight   (inflight),
        .o_busy       (busy)
    );

    // Stand-in adder: known operand pairs only, registered inputs then output.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h00000000, 32'h00000000}: return 32'h00000000;
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40400000, 32'h40400000}: return 32'h40C00000;
            {32'h40800000, 32'h40800000}: return 32'h41000000;
            {32'h40A00000, 32'hC0A00000}: return 32'h00000000;
            default:                      return 32'hFFFFFFFF;
        endcase
    endfunction

    logic [31:0] add_ra, add_rb;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_ra  <= '0;
            add_rb  <= '0;
            fpu_out <= '0;
        end else begin
            add_ra  <= fpu_a;
            add_rb  <= fpu_b;
            fpu_out <= fp_add(add_ra, add_rb);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One cycle: drive at the falling edge, then check outputs.
    task automatic cyc(input string name, input logic [3:0] v, input logic h,
                       input logic [3:0] e_rdy, input logic [3:0] e_rv,
                       input logic [31:0] e_rd, input logic [1:0] e_inf);
        @(negedge clk);
        req_valid = v;
        hold      = h;
        #1;
        check({name, "_rdy"}, 32'(req_ready), 32'(e_rdy));
        check({name, "_rv"}, 32'(resp_valid), 32'(e_rv));
        check({name, "_inf"}, 32'(inflight), 32'(e_inf));
        if (e_rv != 4'b0) check({name, "_rd"}, resp_data, e_rd);
        if (e_rdy == 4'b0) begin
            check({name, "_fa0"}, fpu_a, 32'h0);
            check({name, "_fb0"}, fpu_b, 32'h0);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        hold      = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] sums [4];
    logic [3:0]  e_rv;
    logic [1:0]  e_inf;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        hold      = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        set_ops(0, 32'h3F800000, 32'h40000000);
        #3;
        check("rst_rdy", 32'(req_ready), 32'h0);
        check("rst_fa", fpu_a, 32'h0);
        check("rst_fb", fpu_b, 32'h0);
        check("rst_rv", 32'(resp_valid), 32'h0);
        check("rst_inf", 32'(inflight), 32'h0);
        check("rst_ptr", 32'(dut.r_ptr), 32'h0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;

        // 1. Single request
        cyc("t1c0", 4'b0001, 1'b0, 4'b0001, 4'b0, 32'h0, 2'd0);
        check("t1_fa", fpu_a, 32'h3F800000);
        check("t1_fb", fpu_b, 32'h40000000);
        check("t1_busy", 32'(busy), 32'h1);
        cyc("t1c1", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd1);
        cyc("t1c2", 4'b0000, 1'b0, 4'b0000, 4'b0001, 32'h40400000, 2'd1);
        cyc("t1c3", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd0);
        check("t1_ptr", 32'(dut.r_ptr), 32'h1);
        check("t1_idle", 32'(busy), 32'h0);

        // 2. All four valid continuously
        pulse_reset();
        set_ops(0, 32'h3F800000, 32'h3F800000);
        set_ops(1, 32'h40000000, 32'h40000000);
        set_ops(2, 32'h40400000, 32'h40400000);
        set_ops(3, 32'h40800000, 32'h40800000);
        sums[0] = 32'h40000000;
        sums[1] = 32'h40800000;
        sums[2] = 32'h40C00000;
        sums[3] = 32'h41000000;
        for (int c = 0; c <= 10; c++) begin
            e_rv  = (c >= 2 && c <= 9) ? 4'(1 << ((c - 2) % 4)) : 4'b0;
            e_inf = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 8) ? 2'd2 : (c == 9) ? 2'd1 : 2'd0;
            cyc($sformatf("t2c%0d", c), (c < 8) ? 4'b1111 : 4'b0000, 1'b0,
                (c < 8) ? 4'(1 << (c % 4)) : 4'b0000, e_rv,
                (c >= 2) ? sums[(c - 2) % 4] : 32'h0, e_inf);
        end

        // 3. Requesters 0 and 2 with ptr=1
        set_ops(0, 32'h3F800000, 32'h40000000);
        cyc("t3c0", 4'b0001, 1'b0, 4'b0001, 4'b0, 32'h0, 2'd0);
        cyc("t3c1", 4'b0101, 1'b0, 4'b0100, 4'b0, 32'h0, 2'd1);
        cyc("t3c2", 4'b0001, 1'b0, 4'b0001, 4'b0001, 32'h40400000, 2'd2);
        cyc("t3c3", 4'b0000, 1'b0, 4'b0000, 4'b0100, 32'h40C00000, 2'd2);
        cyc("t3c4", 4'b0000, 1'b0, 4'b0000, 4'b0001, 32'h40400000, 2'd1);
        cyc("t3c5", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd0);
        check("t3_ptr", 32'(dut.r_ptr), 32'h1);

        // 4. Hold mid-stream
        set_ops(1, 32'h40000000, 32'h40000000);
        set_ops(3, 32'h40800000, 32'h40800000);
        cyc("t4c0", 4'b1111, 1'b0, 4'b0010, 4'b0, 32'h0, 2'd0);
        cyc("t4c1", 4'b1111, 1'b0, 4'b0100, 4'b0, 32'h0, 2'd1);
        cyc("t4c2", 4'b1111, 1'b1, 4'b0000, 4'b0010, 32'h40800000, 2'd2);
        cyc("t4c3", 4'b1111, 1'b1, 4'b0000, 4'b0100, 32'h40C00000, 2'd1);
        cyc("t4c4", 4'b1111, 1'b1, 4'b0000, 4'b0, 32'h0, 2'd0);
        check("t4_busy", 32'(busy), 32'h1);
        cyc("t4c5", 4'b1111, 1'b0, 4'b1000, 4'b0, 32'h0, 2'd0);
        cyc("t4c6", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd1);
        cyc("t4c7", 4'b0000, 1'b0, 4'b0000, 4'b1000, 32'h41000000, 2'd1);
        cyc("t4c8", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd0);

        // 5. Cancellation to zero still returns a response
        set_ops(1, 32'h40A00000, 32'hC0A00000);
        cyc("t5c0", 4'b0010, 1'b0, 4'b0010, 4'b0, 32'h0, 2'd0);
        cyc("t5c1", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd1);
        cyc("t5c2", 4'b0000, 1'b0, 4'b0000, 4'b0010, 32'h00000000, 2'd1);
        cyc("t5c3", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd0);

        // 6. Reset one cycle after two back-to-back accepts
        cyc("t6c0", 4'b1100, 1'b0, 4'b0100, 4'b0, 32'h0, 2'd0);
        cyc("t6c1", 4'b1000, 1'b0, 4'b1000, 4'b0, 32'h0, 2'd1);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b0000;
        #1;
        check("t6_rst_rv", 32'(resp_valid), 32'h0);
        check("t6_rst_inf", 32'(inflight), 32'h0);
        check("t6_rst_ptr", 32'(dut.r_ptr), 32'h0);
        @(negedge clk);
        #1;
        check("t6_rst_rv2", 32'(resp_valid), 32'h0);
        reset = 1'b0;
        cyc("t6c2", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd0);
        cyc("t6c3", 4'b0001, 1'b0, 4'b0001, 4'b0, 32'h0, 2'd0);
        cyc("t6c4", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd1);
        cyc("t6c5", 4'b0000, 1'b0, 4'b0000, 4'b0001, 32'h40400000, 2'd1);
        cyc("t6c6", 4'b0000, 1'b0, 4'b0000, 4'b0, 32'h0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
